morse_tx: RTL and testbench

Morse transmitter: encodes one character code into timed key-on/key-off intervals on a single `key` output that drives an LED or buzzer. It is the sending-side counterpart of the button-driven Morse receiver in `morse_code_top`. Symbol timing uses the same dot-unit length the receiver calibrates, so a user's own keying speed can be replayed. The block sits between the character/switch logic and the LED outputs.

---
 rtl/morse_pkg.sv | 39 +++
 rtl/morse_tx_rom.sv | 63 ++++++
 rtl/morse_tx.sv | 139 +++++++++++++
 tb/tb_morse_tx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// morse_pkg: definitions shared by the Morse transmitter and receiver.
//   - FSM state encoding of the transmitter
//   - symbol/gap lengths in dot units
//   - MAX_SYMS and the pattern/symbol-count types sized from it
//   - character-code constants (0-25 = A-Z, 26-35 = digits 0-9)
// Build option: MORSE_TX_DIGITS_EN adds the five-symbol digit patterns.
package morse_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StMark,
    StGap,
    StLgap
  } state_e;

  localparam int unsigned DOT_UNITS     = 1;
  localparam int unsigned DASH_UNITS    = 3;
  localparam int unsigned SYM_GAP_UNITS = 1;
  localparam int unsigned LTR_GAP_UNITS = 3;

`ifdef MORSE_TX_DIGITS_EN
  localparam int unsigned MAX_SYMS = 5;
`else
  localparam int unsigned MAX_SYMS = 4;
`endif

  localparam int unsigned SYM_CNT_W = $clog2(MAX_SYMS + 1);

  // Symbol pattern: bit 0 is sent first, 1 = dash.
  typedef logic [MAX_SYMS-1:0]  pat_t;
  typedef logic [SYM_CNT_W-1:0] symcnt_t;

  localparam logic [5:0] CODE_A      = 6'd0;
  localparam logic [5:0] CODE_Z      = 6'd25;
  localparam logic [5:0] CODE_DIGIT0 = 6'd26;
  localparam logic [5:0] CODE_DIGIT9 = 6'd35;

endpackage

// File: rtl/morse_tx_rom.sv
// morse_tx_rom: combinational character-code to Morse pattern lookup.
//   char_code  in   6-bit character index
//   pattern    out  symbol pattern, bit 0 first, 1 = dash
//   count      out  number of symbols (1-4, or 5 for digits)
//   valid      out  code is supported in this build
// Build option: MORSE_TX_DIGITS_EN enables codes 26-35 (digits 0-9).
module morse_tx_rom
  import morse_pkg::*;
(
  input  logic [5:0] char_code,
  output pat_t       pattern,
  output symcnt_t    count,
  output logic       valid
);

  always_comb begin
    pattern = '0;
    count   = '0;
    valid   = 1'b1;
    case (char_code)
      CODE_A: begin pattern = pat_t'(4'b0010); count = 3'd2; end // A .-
      6'd1:   begin pattern = pat_t'(4'b0001); count = 3'd4; end // B -...
      6'd2:   begin pattern = pat_t'(4'b0101); count = 3'd4; end // C -.-.
      6'd3:   begin pattern = pat_t'(4'b0001); count = 3'd3; end // D -..
      6'd4:   begin pattern = pat_t'(4'b0000); count = 3'd1; end // E .
      6'd5:   begin pattern = pat_t'(4'b0100); count = 3'd4; end // F ..-.
      6'd6:   begin pattern = pat_t'(4'b0011); count = 3'd3; end // G --.
      6'd7:   begin pattern = pat_t'(4'b0000); count = 3'd4; end // H ....
      6'd8:   begin pattern = pat_t'(4'b0000); count = 3'd2; end // I ..
      6'd9:   begin pattern = pat_t'(4'b1110); count = 3'd4; end // J .---
      6'd10:  begin pattern = pat_t'(4'b0101); count = 3'd3; end // K -.-
      6'd11:  begin pattern = pat_t'(4'b0010); count = 3'd4; end // L .-..
      6'd12:  begin pattern = pat_t'(4'b0011); count = 3'd2; end // M --
      6'd13:  begin pattern = pat_t'(4'b0001); count = 3'd2; end // N -.
      6'd14:  begin pattern = pat_t'(4'b0111); count = 3'd3; end // O ---
      6'd15:  begin pattern = pat_t'(4'b0110); count = 3'd4; end // P .--.
      6'd16:  begin pattern = pat_t'(4'b1011); count = 3'd4; end // Q --.-
      6'd17:  begin pattern = pat_t'(4'b0010); count = 3'd3; end // R .-.
      6'd18:  begin pattern = pat_t'(4'b0000); count = 3'd3; end // S ...
      6'd19:  begin pattern = pat_t'(4'b0001); count = 3'd1; end // T -
      6'd20:  begin pattern = pat_t'(4'b0100); count = 3'd3; end // U ..-
      6'd21:  begin pattern = pat_t'(4'b1000); count = 3'd4; end // V ...-
      6'd22:  begin pattern = pat_t'(4'b0110); count = 3'd3; end // W .--
      6'd23:  begin pattern = pat_t'(4'b1001); count = 3'd4; end // X -..-
      6'd24:  begin pattern = pat_t'(4'b1101); count = 3'd4; end // Y -.--
      CODE_Z: begin pattern = pat_t'(4'b0011); count = 3'd4; end // Z --..
`ifdef MORSE_TX_DIGITS_EN
      CODE_DIGIT0: begin pattern = 5'b11111; count = 3'd5; end // 0 -----
      6'd27:       begin pattern = 5'b11110; count = 3'd5; end // 1 .----
      6'd28:       begin pattern = 5'b11100; count = 3'd5; end // 2 ..---
      6'd29:       begin pattern = 5'b11000; count = 3'd5; end // 3 ...--
      6'd30:       begin pattern = 5'b10000; count = 3'd5; end // 4 ....-
      6'd31:       begin pattern = 5'b00000; count = 3'd5; end // 5 .....
      6'd32:       begin pattern = 5'b00001; count = 3'd5; end // 6 -....
      6'd33:       begin pattern = 5'b00011; count = 3'd5; end // 7 --...
      6'd34:       begin pattern = 5'b00111; count = 3'd5; end // 8 ---..
      CODE_DIGIT9: begin pattern = 5'b01111; count = 3'd5; end // 9 ----.
`endif
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/morse_tx.sv
// morse_tx: sends one character as timed key-on/key-off intervals.
//   Clk        in   system clock, rising edge
//   Reset      in   asynchronous active-high reset
//   start      in   send char_code (honoured only when idle)
//   char_code  in   character index (see morse_pkg)
//   unit_len   in   dot length in cycles, 0 treated as 1
//   abort      in   cancel the character in progress
//   key        out  high during a dot or dash
//   busy       out  high from LOAD through the inter-letter gap
//   done       out  one-cycle pulse on normal completion
//   err        out  one-cycle pulse after a start with an unsupported code
// Build option: MORSE_TX_DIGITS_EN (digits 0-9 on codes 26-35).
module morse_tx
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_W = 24
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [5:0]        char_code,
  input  logic [UNIT_W-1:0] unit_len,
  input  logic              abort,
  output logic              key,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [UNIT_W+1:0] CNT_ONE = (UNIT_W+2)'(1);

  state_e            state;
  logic [UNIT_W+1:0] cnt;
  logic [UNIT_W-1:0] unit_q;
  pat_t              pat_q;
  symcnt_t           syms_q;

  pat_t              rom_pat;
  symcnt_t           rom_cnt;
  logic              rom_valid;
  logic [UNIT_W-1:0] unit_clamped;

  morse_tx_rom u_rom (
    .char_code (char_code),
    .pattern   (rom_pat),
    .count     (rom_cnt),
    .valid     (rom_valid)
  );

  assign unit_clamped = (unit_len == '0) ? UNIT_W'(1) : unit_len;

  // Two extra bits keep unit x 3 from overflowing.
  function automatic logic [UNIT_W+1:0] dur(input logic [UNIT_W-1:0] u,
                                            input int unsigned units);
    return {2'b00, u} * (UNIT_W+2)'(units);
  endfunction

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= StIdle;
      cnt    <= '0;
      unit_q <= '0;
      pat_q  <= '0;
      syms_q <= '0;
      key    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (abort && (state != StIdle)) begin
        state <= StIdle;
        cnt   <= '0;
        key   <= 1'b0;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          StIdle: begin
            if (start) begin
              if (rom_valid) begin
                // Pattern captured together with the validity decision.
                pat_q  <= rom_pat;
                syms_q <= rom_cnt;
                busy   <= 1'b1;
                state  <= StLoad;
              end else begin
                err <= 1'b1;
              end
            end
          end
          StLoad: begin
            unit_q <= unit_clamped;
            cnt    <= dur(unit_clamped, pat_q[0] ? DASH_UNITS : DOT_UNITS);
            key    <= 1'b1;
            state  <= StMark;
          end
          StMark: begin
            if (cnt == CNT_ONE) begin
              key <= 1'b0;
              if (syms_q > symcnt_t'(1)) begin
                pat_q  <= pat_q >> 1;
                syms_q <= syms_q - symcnt_t'(1);
                cnt    <= dur(unit_q, SYM_GAP_UNITS);
                state  <= StGap;
              end else begin
                cnt   <= dur(unit_q, LTR_GAP_UNITS);
                state <= StLgap;
              end
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          StGap: begin
            if (cnt == CNT_ONE) begin
              cnt   <= dur(unit_q, pat_q[0] ? DASH_UNITS : DOT_UNITS);
              key   <= 1'b1;
              state <= StMark;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          StLgap: begin
            if (cnt == CNT_ONE) begin
              cnt   <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= StIdle;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_morse_tx.sv
// tb_morse_tx: self-checking bench for morse_tx. Expected key/busy/done/err
// waveforms come from a dot/dash string table expanded cycle by cycle.
// Works with or without MORSE_TX_DIGITS_EN defined.
module tb_morse_tx;

  localparam int UNIT_W = 24;
`ifdef MORSE_TX_DIGITS_EN
  localparam bit DIGITS = 1'b1;
`else
  localparam bit DIGITS = 1'b0;
`endif

  logic              Clk = 1'b0;
  logic              Reset;
  logic              start;
  logic [5:0]        char_code;
  logic [UNIT_W-1:0] unit_len;
  logic              abort;
  logic              key, busy, done, err;

  int checks = 0;
  int errors = 0;

  morse_tx #(.UNIT_W(UNIT_W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .start     (start),
    .char_code (char_code),
    .unit_len  (unit_len),
    .abort     (abort),
    .key       (key),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 Clk = ~Clk;

  string morse_tbl [36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-",
    ".....", "-....", "--...", "---..", "----."
  };

  function automatic bit ref_valid(input int c);
    return (c < 26) || (DIGITS && (c < 36));
  endfunction

  function automatic string ref_morse(input int c);
    return ref_valid(c) ? morse_tbl[c] : "";
  endfunction

  // Cycles from first key rise to done, by counting units in the string.
  function automatic int ref_total(input int c, input int ul);
    string s;
    int    units;
    s     = ref_morse(c);
    units = 3 + s.len() - 1;
    for (int i = 0; i < s.len(); i++) units += (s[i] == "-") ? 3 : 1;
    return ((ul == 0) ? 1 : ul) * units;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {28'd0, key, busy, done, err};
  endfunction

  // Sends one valid character and compares every cycle against the expanded
  // model waveform. disturb_at: cycle at which a stray start/unit_len change
  // is injected. chain: issue the next start in the done cycle.
  task automatic send(input logic [5:0] code, input int ul, input int exp_total,
                      input int disturb_at, input bit prestarted,
                      input bit chain, input logic [5:0] code2, input int ul2);
    string      s;
    int         eff, n, rise_idx, done_idx;
    logic [3:0] exp_q[$];
    s   = ref_morse(int'(code));
    eff = (ul == 0) ? 1 : ul;
    exp_q.push_back(4'b0100);
    for (int i = 0; i < s.len(); i++) begin
      n = (s[i] == "-") ? 3 * eff : eff;
      repeat (n) exp_q.push_back(4'b1100);
      if (i < s.len() - 1) repeat (eff) exp_q.push_back(4'b0100);
    end
    repeat (3 * eff) exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0010);
    if (!chain) exp_q.push_back(4'b0000);
    if (!prestarted) begin
      start = 1'b1; char_code = code; unit_len = ul[UNIT_W-1:0];
    end
    rise_idx = -1;
    done_idx = -1;
    for (int k = 1; k <= exp_q.size(); k++) begin
      @(posedge Clk); #1;
      if (key && rise_idx < 0) rise_idx = k;
      if (done && done_idx < 0) done_idx = k;
      chk($sformatf("wave code %0d ul %0d cycle %0d", code, ul, k), outs(),
          {28'd0, exp_q[k-1]});
      start = (k == disturb_at);
      if (k == disturb_at) begin
        char_code = 6'd4; unit_len = UNIT_W'(9);
      end
      if (chain && k == exp_q.size()) begin
        start = 1'b1; char_code = code2; unit_len = ul2[UNIT_W-1:0];
      end
    end
    chk($sformatf("rise latency code %0d", code), rise_idx, 2);
    chk($sformatf("rise to done code %0d", code), done_idx - rise_idx, exp_total);
  endtask

  task automatic send_bad(input logic [5:0] code);
    start = 1'b1; char_code = code; unit_len = UNIT_W'(3);
    @(posedge Clk); #1;
    start = 1'b0;
    chk($sformatf("err pulse code %0d", code), outs(), 32'b0001);
    repeat (5) begin
      @(posedge Clk); #1;
      chk($sformatf("err quiet code %0d", code), outs(), 32'b0000);
    end
  endtask

  // Starts T at unit 10 and stops in its fifth mark cycle.
  task automatic start_t_to_mark5();
    start = 1'b1; char_code = 6'd19; unit_len = UNIT_W'(10);
    for (int k = 1; k <= 6; k++) begin
      @(posedge Clk); #1;
      start = 1'b0;
    end
    chk("T key high in mark", {31'd0, key}, 32'd1);
  endtask

  typedef struct {
    logic [5:0] code;
    int         ul;
    int         total;  // -1: code must be rejected
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [5:0] rc;
    int         ru;

    Reset = 1'b1; start = 1'b0; char_code = '0; unit_len = '0; abort = 1'b0;
    #1;
    chk("reset outputs", outs(), 32'b0000);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk); #1;
    chk("idle after reset release", outs(), 32'b0000);

    tbl.push_back('{6'd0,  4, 32});  // A: 4 high, 4 low, 12 high, 12 low
    tbl.push_back('{6'd4,  0, 4});   // E, zero length clamped to 1
    tbl.push_back('{6'd19, 2, 12});  // T
    tbl.push_back('{6'd18, 1, 8});   // S
    tbl.push_back('{6'd14, 2, 28});  // O
    tbl.push_back('{6'd25, 1, 14});  // Z
`ifdef MORSE_TX_DIGITS_EN
    tbl.push_back('{6'd30, 1, 14});  // digit 4
    tbl.push_back('{6'd31, 2, 24});  // digit 5: five 2-cycle marks, 6-cycle tail
    tbl.push_back('{6'd26, 1, 22});  // digit 0
    tbl.push_back('{6'd36, 1, -1});
`else
    tbl.push_back('{6'd30, 1, -1});
    tbl.push_back('{6'd26, 1, -1});
`endif
    tbl.push_back('{6'd63, 2, -1});

    foreach (tbl[i]) begin
      if (tbl[i].total < 0) send_bad(tbl[i].code);
      else send(tbl[i].code, tbl[i].ul, tbl[i].total, 0, 1'b0, 1'b0, 6'd0, 0);
    end

    // Q at unit 3; stray start and unit_len=9 during the first dash.
    send(6'd16, 3, 48, 4, 1'b0, 1'b0, 6'd0, 0);

    // New start accepted in the done cycle.
    send(6'd0, 1, 8, 0, 1'b0, 1'b1, 6'd19, 2);
    send(6'd19, 2, 12, 0, 1'b1, 1'b0, 6'd0, 0);

    // Asynchronous reset in the middle of a mark.
    start_t_to_mark5();
    Reset = 1'b1;
    #1;
    chk("reset drops key and busy", outs(), 32'b0000);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (60) begin
      @(posedge Clk); #1;
      chk("quiet after mid-mark reset", outs(), 32'b0000);
    end

    // Abort in the middle of a mark.
    start_t_to_mark5();
    abort = 1'b1;
    @(posedge Clk); #1;
    abort = 1'b0;
    chk("abort returns idle", outs(), 32'b0000);
    repeat (60) begin
      @(posedge Clk); #1;
      chk("quiet after abort", outs(), 32'b0000);
    end
    send(6'd4, 1, 4, 0, 1'b0, 1'b0, 6'd0, 0);

    // Random codes and unit lengths against the string model.
    for (int i = 0; i < 40; i++) begin
      rc = 6'($urandom_range(0, 63));
      ru = int'($urandom_range(0, 4));
      if (ref_valid(int'(rc))) send(rc, ru, ref_total(int'(rc), ru), 0, 1'b0, 1'b0, 6'd0, 0);
      else send_bad(rc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
